syn_fifo_param: RTL and testbench
=================================

# syn_fifo_param

Parametrised synchronous FIFO; next generation of the team's fixed 8-bit × 8-entry `syn_fifo`. It adds configurable width and depth, a show-ahead (first-word-fall-through) mode, an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush. It is a drop-in single-clock buffer between producer and consumer blocks sharing `clk`.

## Interface
- DATA_W, 8: data word width in bits.
- DEPTH, 8: number of entries; power of two, ≥ 2. AW = $clog2(DEPTH).
- FWFT, 0: 0 = registered-read mode, 1 = show-ahead mode.
- AF_THRESH, DEPTH-2: almost_full_o asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty_o asserts when count ≤ AE_THRESH.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clr_i  in  1  synchronous flush.
- wr_en_i  in  1  write request.
- data_i  in  DATA_W  write data.
- rd_en_i  in  1  read request (pop).
- data_o  out  DATA_W  read data.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count ≥ AF_THRESH.
- almost_empty_o  out  1  count ≤ AE_THRESH.
- count_o  out  AW+1  occupancy, 0..DEPTH.
- overflow_o  out  1  one-cycle pulse: write rejected.
- underflow_o  out  1  one-cycle pulse: read rejected.

## Operation
- Storage: DEPTH × DATA_W array, wr_ptr/rd_ptr of AW bits, wrap naturally at DEPTH-1 → 0; occupancy held in registered count (AW+1 bits).
- rd_acc = rd_en_i & ~empty_o. A read from an empty FIFO is rejected even if a write happens in the same cycle.
- wr_acc = wr_en_i & (~full_o | rd_acc). A write while full is accepted only together with an accepted read (count unchanged).
- count_next = count + wr_acc − rd_acc. All flags are registered and computed from count_next, so they always agree with count_o.
- overflow_o ← wr_en_i & ~wr_acc; underflow_o ← rd_en_i & ~rd_acc. Each is high for exactly the cycle after the offending request.
- FWFT=0: on rd_acc, data_o ← mem[rd_ptr] at the edge. Otherwise data_o holds its value.
- FWFT=1: data_o = mem[rd_ptr] while empty_o=0, and 0 while empty_o=1. rd_acc pops the head and data_o shows the next entry after the edge.
- Priority: rst_n low > clr_i > normal read/write.
- clr_i: pointers and count go to 0, all flags take their reset values, data_o goes to 0. Requests in that cycle are discarded and flag no errors. Array contents are not cleared.

## Timing
- Reset (rst_n=0 at an edge): data_o=0, full_o=0, empty_o=1, almost_full_o=0, almost_empty_o=1, count_o=0, overflow_o=0, underflow_o=0, pointers 0.
- Reset asserted mid-operation discards all contents and in-flight requests at that edge.
- Write latency: a word written at edge N is readable from edge N+1. empty_o falls after edge N.
- FWFT=0 read latency: data_o is valid after the edge that accepted rd_en_i (1 cycle).
- FWFT=1 read latency: the head word is visible one cycle after it is written into an empty FIFO. The pop takes effect at the edge.
- Throughput: one write and one read per cycle, sustained, at any occupancy.
- Pointer wrap: entry DEPTH-1 is followed by entry 0 with no bubble.

## Test plan
- Reset then fill (DEPTH=8, FWFT=0): write 0..7 on consecutive cycles → count_o steps 1..8; almost_full_o rises after count reaches 6; full_o=1 after 8th write; a 9th write gives overflow_o=1 for one cycle and count stays 8.
- Drain: read 8 times → data_o=0,1,…,7 one cycle after each read; empty_o=1 after the last read; a 9th read gives an underflow_o pulse and data_o holds 7.
- Wrap and concurrency: write 5 entries, then drive simultaneous read and write for 12 cycles → count_o constant at 5 and output order preserved across the pointer wrap.
- Full plus simultaneous read/write: at count 8, assert wr_en_i and rd_en_i → write accepted, no overflow, count stays 8. On empty with both asserted → read rejected (underflow_o), write accepted, count=1.
- FWFT=1: write 0xA5 into an empty FIFO → data_o=0xA5 the next cycle without a read; read → data_o=0 and empty_o=1.
- Flush and reset mid-stream: at count 4, assert clr_i together with wr_en_i → count_o=0, empty_o=1, no overflow. Refill to 3 entries, drive rst_n=0 for one edge → all outputs at reset values.

Source files
------------

// File: rtl/syn_fifo_param.sv
// syn_fifo_param: parametrised single-clock FIFO with optional show-ahead (FWFT) read port
//   clk, rst_n (sync, active-low), clr_i (sync flush)
//   write side: wr_en_i, data_i      read side: rd_en_i, data_o
//   status: full_o, empty_o, almost_full_o, almost_empty_o, count_o
//   errors: overflow_o, underflow_o (one-cycle pulses for rejected requests)
module syn_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_next;
    logic              rd_acc, wr_acc;

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_acc     = rd_en_i & ~empty_o;
    assign wr_acc     = wr_en_i & (~full_o | rd_acc);
    assign count_next = count_o + CW'(wr_acc) - CW'(rd_acc);

    // Flags come from count_next so they always line up with count_o.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr + AW'(wr_acc);
            rd_ptr         <= rd_ptr + AW'(rd_acc);
            count_o        <= count_next;
            full_o         <= count_next == FULL_C;
            empty_o        <= count_next == '0;
            almost_full_o  <= count_next >= AF_C;
            almost_empty_o <= count_next <= AE_C;
            overflow_o     <= wr_en_i & ~wr_acc;
            underflow_o    <= rd_en_i & ~rd_acc;
        end
    end

    // Array contents survive reset and flush; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && !clr_i && wr_acc)
            mem[wr_ptr] <= data_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_o = empty_o ? '0 : mem[rd_ptr];
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n || clr_i)
                    data_o <= '0;
                else if (rd_acc)
                    data_o <= mem[rd_ptr];
            end
        end
    endgenerate
endmodule

// File: tb/tb_syn_fifo_param.sv
// tb_syn_fifo_param: directed scoreboard bench for syn_fifo_param in registered and show-ahead modes
module tb_syn_fifo_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       clr, wr, rd;
    logic [7:0] din, dout;
    logic       full, empty, af, ae, ov, un;
    logic [3:0] cnt;

    logic       b_clr, b_wr, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [3:0] b_cnt;

    syn_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .wr_en_i(wr), .data_i(din), .rd_en_i(rd),
        .data_o(dout), .full_o(full), .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae),
        .count_o(cnt), .overflow_o(ov), .underflow_o(un)
    );

    syn_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_i(b_clr), .wr_en_i(b_wr), .data_i(b_din), .rd_en_i(b_rd),
        .data_o(b_dout), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .count_o(b_cnt), .overflow_o(b_ov), .underflow_o(b_un)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " data"}, 32'(dout), 0);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " af"}, 32'(af), 0);
        chk({tag, " ae"}, 32'(ae), 1);
        chk({tag, " count"}, 32'(cnt), 0);
        chk({tag, " ov"}, 32'(ov), 0);
        chk({tag, " un"}, 32'(un), 0);
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; din = d; q.push_back(d);
        step();
        wr = 1'b0;
    endtask

    initial begin
        {clr, wr, rd, din} = '0;
        {b_clr, b_wr, b_rd, b_din} = '0;
        step(); step();
        chk_reset("reset");
        rst_n = 1'b1;

        // fill 0..7
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; din = 8'(i); q.push_back(8'(i));
            step();
            chk("fill count", 32'(cnt), 32'(i + 1));
            chk("fill af", 32'(af), 32'(i + 1 >= 6));
            chk("fill ae", 32'(ae), 32'(i + 1 <= 2));
            chk("fill full", 32'(full), 32'(i == 7));
        end
        din = 8'hEE;
        step();
        chk("overflow pulse", 32'(ov), 1);
        chk("overflow count", 32'(cnt), 8);
        wr = 1'b0;
        step();
        chk("overflow one cycle", 32'(ov), 0);

        // drain
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            exp_d = q.pop_front();
            step();
            chk("drain data", 32'(dout), 32'(exp_d));
            chk("drain count", 32'(cnt), 32'(7 - i));
            chk("drain empty", 32'(empty), 32'(i == 7));
        end
        step();
        chk("underflow pulse", 32'(un), 1);
        chk("underflow hold", 32'(dout), 7);
        rd = 1'b0;
        step();
        chk("underflow one cycle", 32'(un), 0);

        // wrap with concurrent traffic
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        chk("wrap prefill", 32'(cnt), 5);
        for (int i = 0; i < 12; i++) begin
            wr = 1'b1; rd = 1'b1; din = 8'(8'h20 + i); q.push_back(din);
            exp_d = q.pop_front();
            step();
            chk("wrap count", 32'(cnt), 5);
            chk("wrap data", 32'(dout), 32'(exp_d));
        end
        wr = 1'b0; rd = 1'b0;

        // full with simultaneous read/write
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        chk("full before rw", 32'(full), 1);
        wr = 1'b1; rd = 1'b1; din = 8'h55; q.push_back(din);
        exp_d = q.pop_front();
        step();
        chk("full rw count", 32'(cnt), 8);
        chk("full rw ov", 32'(ov), 0);
        chk("full rw data", 32'(dout), 32'(exp_d));
        chk("full rw full", 32'(full), 1);
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_d = q.pop_front();
            step();
            chk("full drain data", 32'(dout), 32'(exp_d));
        end
        chk("drained empty", 32'(empty), 1);

        // empty with simultaneous read/write
        wr = 1'b1; din = 8'h66; q.push_back(din);
        step();
        chk("empty rw un", 32'(un), 1);
        chk("empty rw count", 32'(cnt), 1);
        chk("empty rw empty", 32'(empty), 0);
        chk("empty rw data hold", 32'(dout), 32'(exp_d));
        wr = 1'b0; rd = 1'b0;

        // flush with concurrent write
        for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
        chk("pre flush count", 32'(cnt), 4);
        clr = 1'b1; wr = 1'b1; din = 8'h99;
        step();
        clr = 1'b0; wr = 1'b0;
        q.delete();
        chk_reset("flush");

        // refill then reset mid-stream
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
        chk("refill count", 32'(cnt), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset("mid reset");
        q.delete();

        // show-ahead instance
        chk("fwft idle data", 32'(b_dout), 0);
        chk("fwft idle empty", 32'(b_empty), 1);
        b_wr = 1'b1; b_din = 8'hA5;
        step();
        b_wr = 1'b0;
        chk("fwft show", 32'(b_dout), 32'hA5);
        chk("fwft not empty", 32'(b_empty), 0);
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        chk("fwft pop data", 32'(b_dout), 0);
        chk("fwft pop empty", 32'(b_empty), 1);
        b_wr = 1'b1; b_din = 8'h3C;
        step();
        b_din = 8'hC3;
        step();
        b_wr = 1'b0;
        chk("fwft head", 32'(b_dout), 32'h3C);
        chk("fwft count", 32'(b_cnt), 2);
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        chk("fwft next", 32'(b_dout), 32'hC3);
        chk("fwft count after pop", 32'(b_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
